// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam int HDR_BYTES = 4;

  // Shared with the instruction-memory block so both agree on the boot window.
  localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC00000;
  localparam int unsigned DEF_MEM_BYTES = 4096;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed image into instruction memory, holds the core in reset until done.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned                  ADDR_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned                  MEM_BYTES  = DEF_MEM_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_rst_no
);

  state_e                  state_q, state_d;
  logic [31:0]             len_q, len_d;
  logic [1:0]              hdr_cnt_q, hdr_cnt_d;
  logic [31:0]             idx_q, idx_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic        accept;
  logic [31:0] len_full;

  assign rx_ready_o = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign accept     = rx_valid_i && rx_ready_o;
  // Header arrives LSB first, so each byte shifts in from the top.
  assign len_full   = {rx_data_i, len_q[31:8]};

  assign busy_o      = rx_ready_o;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERR);
  assign cpu_rst_no  = (state_q == DONE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d   = LEN;
          len_d     = '0;
          hdr_cnt_d = '0;
          idx_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          len_d     = len_full;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            idx_d = '0;
            if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else if (len_full > 32'(MEM_BYTES)) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_WIDTH'(idx_q);
          wdata_d = DATA_WIDTH'(rx_data_i);
          idx_d   = idx_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data_i;
`endif
          if (idx_q == len_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (rx_data_i == sum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_cnt_q <= hdr_cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader; expected writes queued as bytes are sent.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy, done, err, cpu_rst_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int writes_seen = 0;
  logic [39:0] exp_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  pay [0:4095];

  localparam logic [31:0] BASE = 32'hBFC00000;

  imem_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_no(cpu_rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      logic [39:0] e;
      writes_seen++;
      wr_cyc_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, e[39:8], e[7:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall && ($urandom_range(0, 1) == 1)) begin
      n = $urandom_range(1, 3);
      rx_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        total++;
        if (rx_ready !== 1'b1) begin
          bad++;
          $display("FAIL stall_ready: got %b, required 1", rx_ready);
        end
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 1000; i++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL handshake_timeout: got ready=%b, required 1 within 1000 cycles", rx_ready);
  endtask

  // Full load of pay[0..n-1]; chk_delta corrupts the trailing checksum when that feature is built in.
  task automatic do_load(input int n, input bit stall, input logic [7:0] chk_delta);
    logic [31:0] len = n;
    logic [7:0]  sum = 8'h00;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({BASE + k, pay[k]});
      sum = sum + pay[k];
      send_byte(pay[k], stall);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum + chk_delta, 1'b0);
`else
    if (chk_delta != 8'h00 && sum == 8'h00) $display("note: checksum disabled");
`endif
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_n} !== 46'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_n});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    total++;
    if ({busy, rx_ready, cpu_rst_n} !== 3'b110) begin
      bad++;
      $display("FAIL start_busy: got busy/ready/rst_n=%b, required 110", {busy, rx_ready, cpu_rst_n});
    end
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_payload4();
    int w0 = writes_seen;
    pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'hA0; pay[3] = 8'h00;
    wr_cyc_q.delete();
    do_load(4, 1'b0, 8'h00);
    total++;
    if ({done, cpu_rst_n, busy, err} !== 4'b1100) begin
      bad++;
      $display("FAIL payload4_done: got done/rst_n/busy/err=%b, required 1100", {done, cpu_rst_n, busy, err});
    end
    settle();
    total++;
    if (writes_seen - w0 !== 4) begin
      bad++;
      $display("FAIL payload4_count: got %0d writes, required 4", writes_seen - w0);
    end
    total++;
    if (wr_cyc_q.size() != 4 || wr_cyc_q[3] - wr_cyc_q[0] != 3) begin
      bad++;
      $display("FAIL payload4_back_to_back: got %0d writes not on consecutive cycles, required 4 consecutive",
               wr_cyc_q.size());
    end
  endtask

  task automatic test_zero_len();
    int w0 = writes_seen;
    do_load(0, 1'b0, 8'h00);
    total++;
    if ({done, cpu_rst_n, err} !== 3'b110) begin
      bad++;
      $display("FAIL zero_len_done: got done/rst_n/err=%b, required 110", {done, cpu_rst_n, err});
    end
    settle();
    total++;
    if (writes_seen != w0) begin
      bad++;
      $display("FAIL zero_len_writes: got %0d writes, required 0", writes_seen - w0);
    end
  endtask

  task automatic test_oversize();
    int w0 = writes_seen;
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    total++;
    if ({err, done, cpu_rst_n, rx_ready, busy} !== 5'b10000) begin
      bad++;
      $display("FAIL oversize: got err/done/rst_n/ready/busy=%b, required 10000",
               {err, done, cpu_rst_n, rx_ready, busy});
    end
    settle();
    total++;
    if (writes_seen != w0) begin
      bad++;
      $display("FAIL oversize_writes: got %0d writes, required 0", writes_seen - w0);
    end
  endtask

  task automatic test_max_len();
    for (int k = 0; k < 4096; k++) pay[k] = 8'($urandom);
    do_load(4096, 1'b0, 8'h00);
    settle();
    total++;
    if (done !== 1'b1 || exp_q.size() != 0 || mem_addr !== 32'hBFC00FFF) begin
      bad++;
      $display("FAIL max_len: got done=%b pending=%0d last_addr=%h, required 1 0 bfc00fff",
               done, exp_q.size(), mem_addr);
    end
  endtask

  task automatic test_stall();
    int w0 = writes_seen;
    for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
    do_load(16, 1'b1, 8'h00);
    settle();
    total++;
    if (writes_seen - w0 !== 16 || done !== 1'b1) begin
      bad++;
      $display("FAIL stall_load: got %0d writes done=%b, required 16 writes done=1", writes_seen - w0, done);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] len = 32'd8;
    for (int k = 0; k < 8; k++) pay[k] = 8'(8'hC0 + k);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({BASE + k, pay[k]});
      send_byte(pay[k], 1'b0);
    end
    rx_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_n} !== 46'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_n});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();
    total++;
    if ({busy, cpu_rst_n, exp_q.size() == 0} !== 3'b001) begin
      bad++;
      $display("FAIL mid_reset_idle: got busy/rst_n/drained=%b, required 001", {busy, cpu_rst_n, exp_q.size() == 0});
    end
    do_load(8, 1'b0, 8'h00);
    settle();
    total++;
    if ({done, cpu_rst_n} !== 2'b11 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL reload: got done/rst_n=%b pending=%0d, required 11 0", {done, cpu_rst_n}, exp_q.size());
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int w0;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    do_load(3, 1'b0, 8'h00);
    settle();
    total++;
    if ({done, err} !== 2'b10) begin
      bad++;
      $display("FAIL checksum_good: got done/err=%b, required 10", {done, err});
    end
    w0 = writes_seen;
    do_load(3, 1'b0, 8'h01);
    settle();
    total++;
    if ({done, err, cpu_rst_n} !== 3'b010 || writes_seen - w0 != 3) begin
      bad++;
      $display("FAIL checksum_bad: got done/err/rst_n=%b writes=%0d, required 010 writes=3",
               {done, err, cpu_rst_n}, writes_seen - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_payload4();
    test_zero_len();
    test_oversize();
    test_stall();
    test_reset_mid_load();
    test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory. The fetch path reads that memory little-endian from 0xBFC00000.
- Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian length header, then the payload bytes.
- Writes each payload byte to BASE_ADDR + k. Signals done or error, and holds the core in reset until the load completes.

Parameters:
- ADDR_WIDTH, 32, width of the memory write address.
- DATA_WIDTH, 8, width of the memory write data; one byte per write.
- BASE_ADDR, 32'hBFC00000, address written by payload byte 0.
- MEM_BYTES, 4096, capacity; a header length above this is an error.

Ports:
- clk_i  in  1  single clock; everything is sampled on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a load.
- rx_data_i  in  8  incoming stream byte.
- rx_valid_i  in  1  rx_data_i is valid.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  byte write strobe.
- mem_addr_o  out  ADDR_WIDTH  byte write address.
- mem_wdata_o  out  DATA_WIDTH  byte write data.
- busy_o  out  1  a load is in progress.
- done_o  out  1  load completed successfully; sticky.
- err_o  out  1  load aborted; sticky.
- cpu_rst_no  out  1  active-low core reset; released only when done.

Behaviour:
- Reset values (applied asynchronously): state IDLE; rx_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0, cpu_rst_no=0. All counters are cleared.
- A byte transfers only on a cycle where rx_valid_i and rx_ready_o are both 1. rx_ready_o is combinational from state: 1 in LEN, DATA and CHK; 0 otherwise.
- IDLE: start_i moves to LEN and sets busy_o=1.
- LEN: accepts 4 bytes, LSB first, into len[31:0]. After the 4th byte:
  - len==0 -> DONE.
  - len>MEM_BYTES -> ERR.
  - otherwise -> DATA with idx=0.
- DATA: each accepted byte is written one cycle later, with mem_we_o=1 for exactly one cycle, mem_addr_o=BASE_ADDR+idx and mem_wdata_o=byte. idx then increments.
  - After byte idx==len-1 is accepted: go to CHK if CHECKSUM_EN is defined, else DONE.
  - Back-to-back transfers are supported: one byte per cycle, one write per cycle.
- Address arithmetic is ADDR_WIDTH-bit unsigned. idx is at most MEM_BYTES-1, so the address never wraps past BASE_ADDR+MEM_BYTES-1.
- DONE: done_o=1, busy_o=0, cpu_rst_no=1.
  - The final write strobe still occurs in the cycle after entering DONE.
- ERR: err_o=1, busy_o=0, cpu_rst_no=0.
  - Writes already issued are not undone.
- start_i in DONE or ERR clears done_o/err_o, drives cpu_rst_no=0, and enters LEN.
- start_i in LEN, DATA or CHK is ignored.
- A rising edge of rst_ni mid-load resumes in IDLE. The core stays in reset.
- Simultaneous start_i and rx_valid_i in IDLE: the byte is not accepted, because rx_ready_o is 0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all payload bytes is kept; the header is excluded.
  - After the payload, state CHK accepts one checksum byte. If it equals the sum -> DONE; else -> ERR.
  - With len==0 the flow still passes through CHK, and the expected value is 8'h00.
- Undefined: no CHK state, no sum register; DATA goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum typedef (IDLE, LEN, DATA, CHK, DONE, ERR);
  - localparam HDR_BYTES=4;
  - the default BASE_ADDR and MEM_BYTES constants, shared with the instruction-memory block.
- The loader is a single module with no sub-module. Its FSM plus counters stay well under 400 lines.

Test Plan:
- Payload of 4 bytes:
  - Stimulus: start_i, then header 04 00 00 00, then payload 13 05 A0 00 sent back-to-back.
  - Required: four writes to BFC00000..BFC00003 with data 13,05,A0,00 on consecutive cycles; then done_o=1 and cpu_rst_no=1.
- Zero-length load:
  - Stimulus: header 00 00 00 00.
  - Required: no mem_we_o pulse; DONE reached on the cycle after the 4th header byte.
- Oversize load:
  - Stimulus: header 01 10 00 00 (4097 bytes).
  - Required: err_o=1, cpu_rst_no=0, zero writes, rx_ready_o=0.
- Stalled stream:
  - Stimulus: rx_valid_i toggled randomly during a 16-byte load.
  - Required: exactly 16 writes with correct addresses and data; rx_ready_o held 1 during the stalls.
- Reset mid-load:
  - Stimulus: rst_ni pulsed low after 2 of 8 payload bytes.
  - Required: all outputs are at their reset values immediately; a subsequent full load completes correctly.
- With IMEM_LOADER_CHECKSUM_EN:
  - Stimulus: payload 01 02 03, then checksum 06.
  - Required: DONE.
  - Stimulus: the same load with checksum 07.
  - Required: ERR, after 3 writes have been issued.
